// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
// Optional feature macro used by the arbiter: SDRAM_ARB_TIMEOUT_EN.
package sdram_arb_pkg;

  // Arbiter transaction states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Read data returned to the requester when the controller never answers.
  localparam logic [15:0] TIMEOUT_FILL = 16'hDEAD;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the search starts at the port after
// 'last' and wraps from NPORTS-1 back to 0.
module rr_pick #(
  parameter int NPORTS = 4
) (
  input  logic [NPORTS-1:0]         req,
  input  logic [$clog2(NPORTS)-1:0] last,
  output logic                      valid,
  output logic [$clog2(NPORTS)-1:0] index
);

  localparam int IW = $clog2(NPORTS);

  logic [IW-1:0] cand;

  // Walk the candidates from farthest to nearest so the nearest request wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    valid = |req;
    index = '0;
    cand  = '0;
    for (int off = NPORTS; off >= 1; off--) begin
      cand = IW'((int'(last) + off) % NPORTS);
      if (req[cand]) index = cand;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter that multiplexes NPORTS requesters onto a single SDRAM
// controller command port, one transaction at a time.
// Optional: define SDRAM_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT cycles.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NPORTS    = 4,
  parameter int ADDRWIDTH = 24,
  parameter int TIMEOUT   = 255
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NPORTS-1:0]                   req,
  input  logic [NPORTS-1:0]                   we,
  input  logic [NPORTS-1:0][ADDRWIDTH-1:0]    addr,
  input  logic [NPORTS-1:0][15:0]             wdata,
  input  logic [NPORTS-1:0][1:0]              bytesel,
  output logic [NPORTS-1:0]                   ack,
  output logic [15:0]                         rdata,
  output logic [$clog2(NPORTS)-1:0]           grant,
  output logic                                mem_req,
  output logic                                mem_we,
  output logic [ADDRWIDTH-1:0]                mem_addr,
  output logic [15:0]                         mem_din,
  output logic [1:0]                          mem_bytesel,
  input  logic                                mem_ack,
  input  logic [15:0]                         mem_dout,
  output logic                                timeout_err
);

  localparam int GW = $clog2(NPORTS);

  arb_state_t    state, state_nxt;
  logic          pick_valid;
  logic [GW-1:0] pick_idx;
  logic          take;      // IDLE accepts a request this cycle
  logic          complete;  // WAIT sees mem_ack this cycle
  logic          tmo;       // WAIT gives up this cycle

  rr_pick #(.NPORTS(NPORTS)) u_rr_pick (
    .req   (req),
    .last  (grant),
    .valid (pick_valid),
    .index (pick_idx)
  );

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic and single-cycle transaction strobes.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    complete  = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          take      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;  // mem_ack is ignored until WAIT
      WAIT: begin
        if (mem_ack) begin
          complete  = 1'b1;
          state_nxt = DONE;
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          tmo       = 1'b1;
          state_nxt = DONE;
        end
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner's command, hold it through WAIT, capture read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant       <= GW'(NPORTS - 1);  // port 0 wins first after reset
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      mem_bytesel <= '0;
      rdata       <= '0;
    end else begin
      if (take) begin
        grant       <= pick_idx;
        mem_req     <= 1'b1;
        mem_we      <= we[pick_idx];
        mem_addr    <= addr[pick_idx];
        mem_din     <= wdata[pick_idx];
        mem_bytesel <= bytesel[pick_idx];
      end
      if (complete) begin
        mem_req <= 1'b0;
        if (!mem_we) rdata <= mem_dout;
      end
      if (tmo) begin
        mem_req <= 1'b0;
        rdata   <= TIMEOUT_FILL;
      end
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  // Count consecutive WAIT cycles; cleared whenever WAIT is left.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                wait_cnt <= '0;
    else if (state == WAIT && state_nxt == WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
    else                                         wait_cnt <= '0;
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) timeout_err <= 1'b0;
    else if (tmo) timeout_err <= 1'b1;
  end
`else
  assign timeout_err = 1'b0;
`endif

  // Completion pulse to the served port while in DONE.
  always_comb begin
    ack = '0;
    if (state == DONE) ack[grant] = 1'b1;
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed scenarios followed by
// randomized transactions checked against a round-robin reference model.
module tb_sdram_port_arbiter;

  localparam int NP = 4;
  localparam int AW = 24;
  localparam int GW = $clog2(NP);

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [NP-1:0]          req, we;
  logic [NP-1:0][AW-1:0]  addr;
  logic [NP-1:0][15:0]    wdata;
  logic [NP-1:0][1:0]     bytesel;
  logic [NP-1:0]          ack;
  logic [15:0]            rdata;
  logic [GW-1:0]          grant;
  logic                   mem_req, mem_we;
  logic [AW-1:0]          mem_addr;
  logic [15:0]            mem_din;
  logic [1:0]             mem_bytesel;
  logic                   mem_ack;
  logic [15:0]            mem_dout;
  logic                   timeout_err;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          model_last;
  logic [15:0] exp_rdata;

  sdram_port_arbiter #(.NPORTS(NP), .ADDRWIDTH(AW), .TIMEOUT(255)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .bytesel     (bytesel),
    .ack         (ack),
    .rdata       (rdata),
    .grant       (grant),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_bytesel (mem_bytesel),
    .mem_ack     (mem_ack),
    .mem_dout    (mem_dout),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference choice: lowest requesting port above the last served one,
  // otherwise the lowest requesting port overall.
  function automatic int model_pick(input logic [NP-1:0] r, input int last);
    for (int p = 0; p < NP; p++) if (r[p] && p > last) return p;
    for (int p = 0; p < NP; p++) if (r[p]) return p;
    return -1;
  endfunction

  function automatic logic [63:0] pack_fields(input logic w, input logic [1:0] bs,
                                              input logic [15:0] d, input logic [AW-1:0] a);
    return {21'b0, w, bs, d, a};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0; bytesel = '0;
    mem_ack = 1'b0; mem_dout = '0;
    @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_fields", pack_fields(mem_we, mem_bytesel, mem_din, mem_addr), 0);
    check("rst_rdata", rdata, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_grant", grant, NP - 1);
    reset_n    = 1'b1;
    model_last = NP - 1;
    exp_rdata  = '0;
  endtask

  // One full transaction, entered and left at a falling edge in IDLE.
  task automatic run_txn(input int lat, input logic [15:0] dout, input bit stray,
                         input bit drop_req, input bit release_on_ack, output int served);
    int          p;
    logic [63:0] fields;
    p      = model_pick(req, model_last);
    served = p;
    check("idle_no_mem_req", mem_req, 0);
    @(negedge clk);
    check("mem_req_rise", mem_req, 1);
    check("grant", grant, p);
    fields = pack_fields(we[p], bytesel[p], wdata[p], addr[p]);
    check("mem_fields", pack_fields(mem_we, mem_bytesel, mem_din, mem_addr), fields);
    model_last = p;
    if (stray) mem_ack = 1'b1;  // arrives in ISSUE and must be ignored
    mem_dout = ~dout;
    if (drop_req) req[p] = 1'b0;
    addr[p]    = AW'($urandom);
    wdata[p]   = 16'($urandom);
    we[p]      = ~we[p];
    bytesel[p] = ~bytesel[p];
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      check("mem_req_hold", mem_req, 1);
      check("mem_fields_hold", pack_fields(mem_we, mem_bytesel, mem_din, mem_addr), fields);
    end
    mem_ack  = 1'b1;
    mem_dout = dout;
    @(negedge clk);
    mem_ack  = 1'b0;
    mem_dout = 16'($urandom);
    if (!fields[42]) exp_rdata = dout;
    check("ack_pulse", ack, 64'(1) << p);
    check("mem_req_drop", mem_req, 0);
    check("rdata", rdata, exp_rdata);
    if (release_on_ack) req[p] = 1'b0;
    @(negedge clk);
    check("ack_single", ack, 0);
  endtask

  initial begin
    int s;
    int seq[5];
    int n;

    do_reset();

    // Scenario 1: port 2 read of 0x000100, controller answers 3 cycles later.
    req = 4'b0100; addr[2] = 24'h000100; we[2] = 1'b0;
    run_txn(3, 16'h1234, 1'b0, 1'b0, 1'b1, s);
    check("s1_port", s, 2);
    check("s1_rdata", rdata, 16'h1234);
    check("s1_grant", grant, 2);
    repeat (2) begin
      @(negedge clk);
      check("s1_no_regrant", {ack, mem_req}, 0);
    end

    // Scenario 2: all ports requesting continuously.
    do_reset();
    req = '1;
    seq = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      run_txn($urandom_range(1, 4), 16'($urandom), 1'b0, 1'b0, 1'b0, s);
      check("s2_rr_order", s, seq[k]);
    end
    req = '0;

    // Scenario 3: port 1 write; stray mem_ack during ISSUE.
    req = 4'b0010; we[1] = 1'b1; wdata[1] = 16'hBEEF; bytesel[1] = 2'b01;
    run_txn(4, 16'h5555, 1'b1, 1'b0, 1'b1, s);
    check("s3_port", s, 1);
    check("s3_rdata_unchanged", rdata, exp_rdata);

    // Scenario 4: port 3 drops req right after mem_req rises.
    req = 4'b1000; we[3] = 1'b0;
    run_txn(2, 16'hA5A5, 1'b0, 1'b1, 1'b0, s);
    check("s4_port", s, 3);
    check("s4_rdata", rdata, 16'hA5A5);

    // Scenario 5: reset pulsed during WAIT.
    req = 4'b1100;
    @(negedge clk);
    check("s5_mem_req", mem_req, 1);
    check("s5_grant", grant, 2);
    @(negedge clk);
    check("s5_wait", mem_req, 1);
    #2 reset_n = 1'b0;
    #1;
    check("s5_async_drop", mem_req, 0);
    check("s5_grant_rst", grant, NP - 1);
    check("s5_no_ack", ack, 0);
    @(negedge clk);
    check("s5_no_ack_late", ack, 0);
    reset_n = 1'b1; model_last = NP - 1; exp_rdata = '0;
    req = '1;
    run_txn(2, 16'h0F0F, 1'b0, 1'b0, 1'b0, s);
    check("s5_port0_next", s, 0);
    req = '0;

    // Randomized traffic against the reference model.
    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < NP; p++) begin
        addr[p]    = AW'($urandom);
        wdata[p]   = 16'($urandom);
        bytesel[p] = 2'($urandom);
        we[p]      = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 4) == 0) begin
        req = '0; mem_ack = 1'b1;  // stray ack while IDLE
        @(negedge clk);
        mem_ack = 1'b0;
        check("idle_stray_ack", {ack, mem_req}, 0);
      end
      req = NP'($urandom);
      if (req == '0) req[$urandom_range(0, NP - 1)] = 1'b1;
      run_txn($urandom_range(1, 5), 16'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s);
    end
    req = '0;
    @(negedge clk);

`ifdef SDRAM_ARB_TIMEOUT_EN
    // Scenario 6: controller never answers.
    req = 4'b0001; mem_ack = 1'b0;
    @(negedge clk);
    check("s6_mem_req", mem_req, 1);
    n = 0;
    while (ack == '0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("s6_cycles", n, 256);
    check("s6_ack", ack, 1);
    check("s6_rdata", rdata, 16'hDEAD);
    check("s6_timeout_err", timeout_err, 1);
    check("s6_mem_req_drop", mem_req, 0);
    req = '0; model_last = 0; exp_rdata = 16'hDEAD;
    @(negedge clk);
    check("s6_sticky", timeout_err, 1);
    req = 4'b0010;
    run_txn(2, 16'h1111, 1'b0, 1'b0, 1'b1, s);
    check("s6_sticky_after_txn", timeout_err, 1);
    do_reset();
`else
    // Without the timeout feature WAIT lasts as long as the controller needs.
    n = 0;
    req = 4'b0100; we[2] = 1'b0;
    run_txn(300, 16'hC0DE, 1'b0, 1'b0, 1'b1, s);
    check("long_wait_rdata", rdata, 16'hC0DE);
    check("no_timeout_err", timeout_err, n);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 The block SHALL have parameter NPORTS, default 4, giving the number of requester ports (2..8).
REQ-002 The block SHALL have parameter ADDRWIDTH, default 24, giving the word-address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, giving the maximum wait cycles for mem_ack.
REQ-004 Port clk SHALL be: clk  input  1  sole clock; all logic rising-edge.
REQ-005 Port reset_n SHALL be: reset_n  input  1  asynchronous active-low reset.
REQ-006 Ports SHALL be: req  input  NPORTS  per-port level request; we  input  NPORTS  per-port write flag.
REQ-007 Ports SHALL be: addr  input  NPORTS x ADDRWIDTH  per-port address; wdata  input  NPORTS x 16  per-port write data; bytesel  input  NPORTS x 2  per-port byte enables.
REQ-008 Ports SHALL be: ack  output  NPORTS  one-cycle completion pulse; rdata  output  16  shared read data; grant  output  $clog2(NPORTS)  index of the last-served port.
REQ-009 Ports SHALL be: mem_req, mem_we  output  1; mem_addr  output  ADDRWIDTH; mem_din  output  16; mem_bytesel  output  2  (controller command side).
REQ-010 Ports SHALL be: mem_ack  input  1  controller completion; mem_dout  input  16  controller read data; timeout_err  output  1  sticky timeout flag.

Function
REQ-011 The FSM SHALL have states IDLE, ISSUE, WAIT, DONE.
REQ-012 In IDLE with any req high, the block SHALL select a port round-robin, starting at the port after grant and wrapping from NPORTS-1 to 0, latch that port's we/addr/wdata/bytesel, and move to ISSUE.
REQ-013 In ISSUE, the block SHALL assert mem_req with the latched fields and move to WAIT; mem_req SHALL be high exactly one cycle after the IDLE cycle that sampled req.
REQ-014 mem_req and the mem_* fields SHALL stay stable from ISSUE until mem_ack is sampled high in WAIT.
REQ-015 On mem_ack in WAIT, the block SHALL deassert mem_req, register mem_dout into rdata (reads only; writes leave rdata unchanged), and move to DONE.
REQ-016 In DONE, ack[grant] SHALL be high for exactly one cycle; the FSM SHALL then return to IDLE, so a requester deasserting req on ack is never re-granted.
REQ-017 A req that falls during ISSUE or WAIT SHALL NOT abort the transaction; the transaction completes and ack still pulses.
REQ-018 With every req high continuously, each port SHALL be served once per NPORTS transactions, in ascending cyclic order.
REQ-019 mem_ack sampled outside WAIT SHALL be ignored.

Reset
REQ-020 While reset_n is low, the FSM SHALL be IDLE, and ack, mem_req, mem_we, mem_addr, mem_din, mem_bytesel, rdata and timeout_err SHALL be 0, with grant = NPORTS-1 so port 0 wins first.
REQ-021 Reset asserted mid-transaction SHALL drop mem_req immediately (asynchronously), and no ack SHALL be issued for the aborted transaction.

Configuration
REQ-022 With macro SDRAM_ARB_TIMEOUT_EN defined, a WAIT-cycle counter SHALL be active; if it reaches TIMEOUT without mem_ack, the block SHALL drop mem_req, set rdata to 16'hDEAD, set timeout_err sticky high until reset, and enter DONE.
REQ-023 Without SDRAM_ARB_TIMEOUT_EN, WAIT SHALL last indefinitely, and timeout_err SHALL be constant 0.

Structure
REQ-024 A shared package sdram_arb_pkg SHALL hold the state enum typedef and the timeout fill constant 16'hDEAD.
REQ-025 Round-robin selection SHALL be a sub-module rr_pick (inputs req vector and last grant; outputs valid and index), purely combinational.

Verification
REQ-026 Scenario 1: after reset, port 2 reads addr 0x000100, and mem_ack comes 3 cycles after mem_req with mem_dout=0x1234 -> mem_req rises 1 cycle after req; ack[2] pulses once; rdata=0x1234; grant=2.
REQ-027 Scenario 2: ports 0..3 all held high -> grant sequence 0,1,2,3,0, with no port served twice before all others.
REQ-028 Scenario 3: port 1 writes wdata=0xBEEF, bytesel=2'b01 -> mem_we=1, mem_din=0xBEEF, mem_bytesel=01 stable until mem_ack; rdata unchanged.
REQ-029 Scenario 4: req[3] dropped in the cycle after mem_req rises -> transaction completes and ack[3] still pulses.
REQ-030 Scenario 5: reset_n pulsed low during WAIT -> mem_req drops in the same cycle, no ack, and the next grant goes to port 0.
REQ-031 Scenario 6 (SDRAM_ARB_TIMEOUT_EN defined): mem_ack is never returned -> after 255 WAIT cycles, ack pulses, rdata=0xDEAD, and timeout_err=1 until reset.
